// File: rtl/syn_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syn_fifo_pkg
// Purpose  : Shared defaults, depth helper and parameter range check for
//            the single-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package syn_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  // Snapshot of the decoded status flags, handy for wrappers and monitors.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit fifo_params_ok(input int data_width,
                                        input int addr_width,
                                        input int afull_th,
                                        input int aempty_th);
    int depth;
    depth = fifo_depth(addr_width);
    return (data_width >= 1) && (addr_width >= 2) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/syn_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : syn_fifo_mem
// Purpose  : Simple dual-port storage array: one synchronous write port and
//            one asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int C_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [0:C_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/syn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : syn_fifo
// Purpose  : Single-clock FIFO with fill count, almost-full/empty thresholds
//            and overflow/underflow pulses. Define SYN_FIFO_FWFT_EN for a
//            first-word-fall-through read port; default is registered output.
// Revision : 1.0 - initial release
// ============================================================================
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_TH   = fifo_depth(ADDR_WIDTH) - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 C_PTR_W     = ADDR_WIDTH + 1;
  localparam logic [C_PTR_W-1:0] C_DEPTH     = C_PTR_W'(fifo_depth(ADDR_WIDTH));
  localparam logic [C_PTR_W-1:0] C_AFULL_TH  = C_PTR_W'(AFULL_TH);
  localparam logic [C_PTR_W-1:0] C_AEMPTY_TH = C_PTR_W'(AEMPTY_TH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (!fifo_params_ok(DATA_WIDTH, ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $error("syn_fifo: parameter out of range");
  end

  logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [C_PTR_W-1:0]    count_w;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc_w;
  logic                  rd_acc_w;
  logic [DATA_WIDTH-1:0] rd_data_w;

  // Wrap bit in the pointer MSB makes the modulo difference the exact fill level.
  assign count_w  = wr_ptr_q - rd_ptr_q;
  assign full_w   = (count_w == C_DEPTH);
  assign empty_w  = (count_w == '0);

  // Acceptance looks only at this cycle's flags; a same-cycle pop never frees room.
  assign wr_acc_w = wr_en & ~full_w;
  assign rd_acc_w = rd_en & ~empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = wr_en & full_w;
    underflow_d = rd_en & empty_w;
    if (wr_acc_w) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (rd_acc_w) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  syn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc_w),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (rd_data_w)
  );

`ifdef SYN_FIFO_FWFT_EN
  // Head word is presented directly; rd_en only acknowledges it.
  assign data_out = rd_data_w;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc_w) begin
      data_out_d = rd_data_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`endif

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_w >= C_AFULL_TH);
  assign almost_empty = (count_w <= C_AEMPTY_TH);
  assign count        = count_w;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_syn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_fifo
// Purpose  : Directed scoreboard bench for syn_fifo (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_fifo;

  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int DEPTH     = 256;
  localparam int AFULL_TH  = 252;
  localparam int AEMPTY_TH = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  syn_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_TH   (AFULL_TH),
    .AEMPTY_TH  (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb_q[$];
  logic          rd_fired = 1'b0;
  logic          exp_ovf  = 1'b0;
  logic          exp_unf  = 1'b0;
  logic [DW-1:0] exp_hold = '0;
  logic          chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances using the flags seen before the edge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
    int            sz;
    logic          wa, ra;
    logic [DW-1:0] popped;
    wr_en   = wr;
    data_in = d;
    rd_en   = rd;
    sz = model_q.size();
    wa = wr && (sz < DEPTH);
    ra = rd && (sz > 0);
    @(posedge clk);
    #1;
    if (ra) begin
      popped = model_q.pop_front();
      sb_q.push_back(popped);
    end
    if (wa) model_q.push_back(d);
    exp_ovf  = wr && (sz == DEPTH);
    exp_unf  = rd && (sz == 0);
    rd_fired = ra;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
  endtask

  // Monitor: status every cycle, read data popped from the scoreboard when a read fired.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        32'(count),        32'(model_q.size()));
      chk("empty",        32'(empty),        32'(model_q.size() == 0));
      chk("full",         32'(full),         32'(model_q.size() == DEPTH));
      chk("almost_full",  32'(almost_full),  32'(model_q.size() >= AFULL_TH));
      chk("almost_empty", 32'(almost_empty), 32'(model_q.size() <= AEMPTY_TH));
      chk("overflow",     32'(overflow),     32'(exp_ovf));
      chk("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SYN_FIFO_FWFT_EN
      if (model_q.size() > 0) chk("data_out_fwft", 32'(data_out), 32'(model_q[0]));
`else
      if (rd_fired) begin
        rd_fired = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=0 expected=1 time=%0t", $time);
        end else begin
          exp_hold = sb_q.pop_front();
        end
      end
      chk("data_out", 32'(data_out), 32'(exp_hold));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"},        32'(count),        32'd0);
    chk({tag, "_empty"},        32'(empty),        32'd1);
    chk({tag, "_full"},         32'(full),         32'd0);
    chk({tag, "_almost_full"},  32'(almost_full),  32'd0);
    chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_overflow"},     32'(overflow),     32'd0);
    chk({tag, "_underflow"},    32'(underflow),    32'd0);
`ifndef SYN_FIFO_FWFT_EN
    chk({tag, "_data_out"},     32'(data_out),     32'd0);
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_state("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Four writes, no reads, then read back.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // Read on empty, then read on empty together with a write.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Fill, overflow, then full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i) ^ 8'h5A, 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hDD, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Half full, then 600 streaming write+read cycles across pointer wrap.
    for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 8'(i * 7 + 3), 1'b0);
    for (int i = 0; i < 600; i++) step(1'b1, 8'(i * 3 + 1), 1'b1);
    for (int i = 0; i < DEPTH / 2; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Async reset at count 100, checked before any further clock edge.
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 9), 1'b0);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    model_q.delete();
    sb_q.delete();
    exp_hold = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    rd_fired = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Single word after reset.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
